// File: rtl/alu_pkg.sv
// Shared types for the sequential shift/add ALU.
// Operation codes, FSM states and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_ROL = 3'd2,
    OP_ROR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_ASR = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_shift_op(op_e o);
    return (o == OP_ROL) || (o == OP_ROR) ||
           (o == OP_SHL) || (o == OP_SHR) ||
           (o == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate step.
// Returns the moved value and the bit pushed out.
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  input  op_e              op,
  output logic [WIDTH-1:0] val_out,
  output logic             bit_out
);

  // one-position move selected by the latched opcode
  always_comb begin
    val_out = val;
    bit_out = 1'b0;
    unique case (1'b1)
      (op == OP_ROL): begin
        val_out = {val[WIDTH-2:0], val[WIDTH-1]};
        bit_out = val[WIDTH-1];
      end
      (op == OP_ROR): begin
        val_out = {val[0], val[WIDTH-1:1]};
        bit_out = val[0];
      end
      (op == OP_SHL): begin
        val_out = {val[WIDTH-2:0], 1'b0};
        bit_out = val[WIDTH-1];
      end
      (op == OP_SHR): begin
        val_out = {1'b0, val[WIDTH-1:1]};
        bit_out = val[0];
      end
      (op == OP_ASR): begin
        val_out = {val[WIDTH-1], val[WIDTH-1:1]};
        bit_out = val[0];
      end
      default: begin
        val_out = val;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_alu.sv
// Iterative add/sub/shift/rotate ALU, one bit per cycle.
// Operands in and results out via valid/ready.
module seq_shift_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  state_e           state_q;
  state_e           state_d;
  op_e              op_in;
  op_e              op_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             zero_q;
  logic [SHW-1:0]   cnt_q;
  logic [SHW-1:0]   n_amt;
  logic             accept;
  logic             in_shift;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  assign op_in     = op_e'(op);
  assign n_amt     = b[SHW-1:0];
  assign in_shift  = is_shift_op(op_in);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};

  assign result = res_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .val     (res_q),
    .op      (op_q),
    .val_out (step_val),
    .bit_out (step_bit)
  );

  // value loaded at accept; shifts start from a
  always_comb begin
    ld_res   = a;
    ld_carry = 1'b0;
    unique case (1'b1)
      (op_in == OP_ADD): begin
        ld_res   = sum[WIDTH-1:0];
        ld_carry = sum[WIDTH];
      end
      (op_in == OP_SUB): begin
        ld_res   = diff[WIDTH-1:0];
        ld_carry = ~diff[WIDTH];
      end
      default: begin
        ld_res   = a;
        ld_carry = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state: shifts with n>0 iterate in BUSY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_shift && (n_amt != '0)) state_d = ST_BUSY;
          else                           state_d = ST_DONE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == SHW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // working register, flags and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
    end else begin
      unique case (1'b1)
        accept: begin
          res_q   <= ld_res;
          carry_q <= ld_carry;
          zero_q  <= (ld_res == '0);
          cnt_q   <= in_shift ? n_amt : '0;
          op_q    <= op_in;
        end
        (state_q == ST_BUSY): begin
          res_q   <= step_val;
          carry_q <= step_bit;
          cnt_q   <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) zero_q <= (step_val == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_alu.sv
// Directed bench for seq_shift_alu (WIDTH=8).
// Hand-computed vectors, latency and handshake checks.
module tb_seq_shift_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;

  int n_chk = 0;
  int n_err = 0;

  seq_shift_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept one op, time it, check outputs, then hand it off
  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [7:0] va,
                        input logic [7:0] vb,
                        input logic [7:0] er,
                        input logic ec,
                        input logic ez,
                        input int el);
    int lat;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1);
    op = o; a = va; b = vb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    if (el > 1) chk({tag, "_busy_rdy"}, in_ready, 0);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cy"}, carry, ec);
    chk({tag, "_z"}, zero, ez);
    tick();
    chk({tag, "_vld_off"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 8'h00; b = 8'h00;
    #12;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_cy", carry, 0);
    chk("rst_z", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("add",    3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1);
    run_op("sub_eq", 3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1);
    run_op("sub_lt", 3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1);
    run_op("rol3",   3'd2, 8'h81, 8'h0B, 8'h0C, 1'b0, 1'b0, 4);
    run_op("asr7",   3'd6, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 8);
    run_op("shr1",   3'd5, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 2);
    run_op("ror1",   3'd3, 8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 2);
    run_op("shl_z",  3'd4, 8'h80, 8'h01, 8'h00, 1'b1, 1'b1, 2);
    run_op("shl_n0", 3'd4, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1);
    run_op("rsv",    3'd7, 8'h33, 8'hFF, 8'h33, 1'b0, 1'b0, 1);
    run_op("add_wr", 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1);

    // backpressure: SHL 0x01 by 2 held for 5 cycles
    out_ready = 1'b0;
    op = 3'd4; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp_lat", lat, 3);
    op = 3'd0; a = 8'h07; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", out_valid, 1);
      chk("bp_res", result, 8'h04);
      chk("bp_cy", carry, 0);
      chk("bp_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_hand_vld", out_valid, 0);
    chk("bp_hand_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_vld", out_valid, 1);
    chk("bp_next_res", result, 8'h08);
    tick();
    chk("bp_next_off", out_valid, 0);

    // reset abort during ROR n=7
    op = 3'd3; a = 8'h81; b = 8'h07; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("ab_vld", out_valid, 0);
    chk("ab_res", result, 0);
    chk("ab_rdy", in_ready, 1);
    chk("ab_cy", carry, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("ab_add", 3'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
